// File: rtl/te_pkg.sv
// Shared trace-encoder constants; the branch-map defaults live here.
package te_pkg;
  localparam int unsigned BRANCH_MAP_LEN   = 31;
  localparam int unsigned BRANCH_COUNT_LEN = $clog2(BRANCH_MAP_LEN + 1);
endpackage

// File: rtl/te_lane_compact.sv
// Combinational lane compactor: exclusive prefix count of set valid lanes plus
// total popcount, so the j-th set lane (ascending index) gets offset j.
module te_lane_compact #(
  parameter int unsigned N     = 2,
  parameter int unsigned OFF_W = $clog2(N + 1) + 1
) (
  input  logic [N-1:0]            valid_i,
  output logic [N-1:0][OFF_W-1:0] offset_o,
  output logic [OFF_W-1:0]        count_o
);

  logic [OFF_W-1:0] w_run;

  always_comb begin
    w_run    = '0;
    offset_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      offset_o[i] = w_run;
      if (valid_i[i]) w_run = w_run + OFF_W'(1);
    end
    count_o = w_run;
  end

endmodule

// File: rtl/te_branch_map_multi.sv
// Multi-lane branch map: packs up to N retired-branch outcomes per cycle into a
// MAP_LEN-bit map in program order, with a conservative ready and flush restart.
module te_branch_map_multi
  import te_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned MAP_LEN = te_pkg::BRANCH_MAP_LEN,
  parameter int unsigned CNT_W   = $clog2(MAP_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N-1:0]       valid_i,
  input  logic [N-1:0]       branch_taken_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CNT_W-1:0]   branches_o,
  output logic               is_full_o,
  output logic               is_empty_o
);

  // One extra bit so free-slot, base+offset and base+k never wrap.
  localparam int unsigned AW = CNT_W + 1;

  logic [MAP_LEN-1:0]   map_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [N-1:0][AW-1:0] w_offset;
  logic [AW-1:0]        w_count;
  logic [AW-1:0]        w_free;
  logic [AW-1:0]        w_base;
  logic [AW-1:0]        w_cnt_sum;
  logic                 w_accept;
  logic [MAP_LEN-1:0]   w_map_d;
  logic [CNT_W-1:0]     w_cnt_d;

  te_lane_compact #(
    .N     (N),
    .OFF_W (AW)
  ) u_compact (
    .valid_i  (valid_i),
    .offset_o (w_offset),
    .count_o  (w_count)
  );

  // Ready uses N rather than popcount(valid_i): no valid->ready path.
  assign w_free     = AW'(MAP_LEN) - {1'b0, cnt_q};
  assign ready_o    = flush_i | (w_free >= AW'(N));
  assign is_full_o  = ~ready_o;
  assign w_accept   = (|valid_i) & ready_o;
  assign w_base     = flush_i ? '0 : {1'b0, cnt_q};
  assign w_cnt_sum  = w_base + w_count;

  always_comb begin
    w_map_d = flush_i ? '0 : map_q;
    w_cnt_d = flush_i ? '0 : cnt_q;
    if (w_accept) begin
      w_cnt_d = w_cnt_sum[CNT_W-1:0];
      // Masked scatter: each map bit picks up the lane that lands on it.
      for (int b = 0; b < int'(MAP_LEN); b++) begin
        for (int i = 0; i < int'(N); i++) begin
          if (valid_i[i] && ((w_base + w_offset[i]) == AW'(b))) begin
            w_map_d[b] = ~branch_taken_i[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q <= '0;
      cnt_q <= '0;
    end else begin
      map_q <= w_map_d;
      cnt_q <= w_cnt_d;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign is_empty_o = (cnt_q == '0);

endmodule

// File: tb/tb_te_branch_map_multi.sv
// Directed bench for te_branch_map_multi: an N=2 and an N=1 instance, MAP_LEN=31.
module tb_te_branch_map_multi;

  logic        clk_i = 1'b0;
  logic        rst_ni;

  logic [1:0]  valid2, taken2;
  logic        flush2;
  logic        ready2, full2, empty2;
  logic [30:0] map2;
  logic [4:0]  br2;

  logic [0:0]  valid1, taken1;
  logic        flush1;
  logic        ready1, full1, empty1;
  logic [30:0] map1;
  logic [4:0]  br1;

  int total = 0;
  int bad   = 0;

  logic [30:0] exp_map;

  always #5 clk_i = ~clk_i;

  te_branch_map_multi #(.N(2), .MAP_LEN(31)) u_dut2 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid2),
    .branch_taken_i (taken2),
    .flush_i        (flush2),
    .ready_o        (ready2),
    .map_o          (map2),
    .branches_o     (br2),
    .is_full_o      (full2),
    .is_empty_o     (empty2)
  );

  te_branch_map_multi #(.N(1), .MAP_LEN(31)) u_dut1 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid1),
    .branch_taken_i (taken1),
    .flush_i        (flush1),
    .ready_o        (ready1),
    .map_o          (map1),
    .branches_o     (br1),
    .is_full_o      (full1),
    .is_empty_o     (empty1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    valid2 = '0; taken2 = '0; flush2 = 1'b0;
    valid1 = '0; taken1 = '0; flush1 = 1'b0;
    repeat (3) cyc();

    check("rst_map2",   32'(map2),   32'h0);
    check("rst_br2",    32'(br2),    32'd0);
    check("rst_empty2", 32'(empty2), 32'd1);
    check("rst_ready2", 32'(ready2), 32'd1);
    check("rst_full2",  32'(full2),  32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    rst_ni = 1'b1;
    cyc();

    // Sparse lanes
    valid2 = 2'b10; taken2 = 2'b00;
    cyc();
    valid2 = 2'b00;
    check("sparse_map",   32'(map2),   32'h1);
    check("sparse_br",    32'(br2),    32'd1);
    check("sparse_empty", 32'(empty2), 32'd0);
    valid2 = 2'b11; taken2 = 2'b01;
    cyc();
    valid2 = 2'b00;
    check("pair_map", 32'(map2), 32'h5);
    check("pair_br",  32'(br2),  32'd3);

    // Fill to 30 with not-taken outcomes
    valid2 = 2'b01; taken2 = 2'b00;
    cyc();
    check("fill_br4", 32'(br2), 32'd4);
    valid2 = 2'b11;
    repeat (13) begin
      check("fill_ready", 32'(ready2), 32'd1);
      cyc();
    end
    valid2 = 2'b00;
    check("full_br",    32'(br2),    32'd30);
    check("full_map",   32'(map2),   32'h3FFF_FFFD);
    check("full_ready", 32'(ready2), 32'd0);
    check("full_full",  32'(full2),  32'd1);

    // Held transfer under backpressure
    valid2 = 2'b11; taken2 = 2'b10;
    repeat (5) begin
      cyc();
      check("stall_br",  32'(br2),  32'd30);
      check("stall_map", 32'(map2), 32'h3FFF_FFFD);
    end

    // Flush while stalled: held lanes land at bit 0 of the new map
    flush2 = 1'b1;
    #1;
    check("flush_ready", 32'(ready2), 32'd1);
    check("flush_full",  32'(full2),  32'd0);
    cyc();
    flush2 = 1'b0; valid2 = 2'b00;
    check("flush_br",  32'(br2),  32'd2);
    check("flush_map", 32'(map2), 32'h1);

    // Build count 7, then flush with nothing valid
    valid2 = 2'b11; taken2 = 2'b00;
    cyc(); cyc();
    valid2 = 2'b01;
    cyc();
    valid2 = 2'b00;
    check("seven_br",  32'(br2),  32'd7);
    check("seven_map", 32'(map2), 32'h7D);
    flush2 = 1'b1;
    cyc();
    flush2 = 1'b0;
    check("fonly_map",   32'(map2),   32'h0);
    check("fonly_br",    32'(br2),    32'd0);
    check("fonly_empty", 32'(empty2), 32'd1);

    // N=1 exact fill: taken alternates, so even bits hold 1
    exp_map = '0;
    for (int i = 0; i < 31; i++) begin
      check("n1_ready", 32'(ready1), 32'd1);
      valid1 = 1'b1;
      taken1 = 1'(i % 2);
      exp_map[i] = ~taken1[0];
      cyc();
    end
    check("n1_br",    32'(br1),    32'd31);
    check("n1_map",   32'(map1),   32'(exp_map));
    check("n1_full",  32'(full1),  32'd1);
    check("n1_ready0",32'(ready1), 32'd0);

    // Asynchronous reset mid-burst with a lane still valid
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_map1",   32'(map1),   32'h0);
    check("arst_br1",    32'(br1),    32'd0);
    check("arst_empty1", 32'(empty1), 32'd1);
    check("arst_full1",  32'(full1),  32'd0);
    check("arst_ready1", 32'(ready1), 32'd1);
    cyc();
    valid1 = 1'b0;
    rst_ni = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
